// File: rtl/avr_fetch_unit.sv
// Instruction-fetch front end of the lab AVR core.
// Resolves rjmp, rcall and ret locally using a return-address stack and hands everything else to decode.
module avr_fetch_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  halted,
    output logic [1:0]            stack_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W = SP_W - 1;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [SP_W-1:0]       sp;
    logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];

    logic                  is_rjmp;
    logic                  is_rcall;
    logic                  is_ret;
    logic                  is_cf;
    logic [ADDR_WIDTH-1:0] k_ext;
    logic [ADDR_WIDTH-1:0] pc_next_seq;
    logic [ADDR_WIDTH-1:0] target;
    logic [IDX_W-1:0]      push_idx;
    logic [IDX_W-1:0]      pop_idx;
    logic                  stack_full;
    logic                  stack_empty;

    assign is_rjmp  = (rom_data[15:12] == 4'b1100);
    assign is_rcall = (rom_data[15:12] == 4'b1101);
    assign is_ret   = (rom_data[15:0] == 16'h9508);
    assign is_cf    = is_rjmp | is_rcall | is_ret;

    // The 12-bit relative offset is either truncated or sign-extended to the pc width.
    generate
        if (ADDR_WIDTH <= 12) begin : g_k_trunc
            assign k_ext = rom_data[ADDR_WIDTH-1:0];
        end else begin : g_k_sext
            assign k_ext = {{(ADDR_WIDTH-12){rom_data[11]}}, rom_data[11:0]};
        end
    endgenerate

    assign pc_next_seq = pc + ADDR_WIDTH'(1);
    assign target      = pc_next_seq + k_ext;

    assign push_idx    = sp[IDX_W-1:0];
    assign pop_idx     = push_idx - IDX_W'(1);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);

    assign rom_addr    = pc;
    assign instr       = rom_data;
    assign instr_pc    = pc;
    assign instr_valid = (state == RUN) && !is_cf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            pc        <= '0;
            sp        <= '0;
            halted    <= 1'b0;
            stack_err <= 2'b00;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (is_rjmp) begin
                        pc <= target;
                    end else if (is_rcall) begin
                        if (stack_full) begin
                            stack_err[0] <= 1'b1;
                            halted       <= 1'b1;
                            state        <= HALT;
                        end else begin
                            stack[push_idx] <= pc_next_seq;
                            sp              <= sp + SP_W'(1);
                            pc              <= target;
                        end
                    end else if (is_ret) begin
                        if (stack_empty) begin
                            stack_err[1] <= 1'b1;
                            halted       <= 1'b1;
                            state        <= HALT;
                        end else begin
                            pc <= stack[pop_idx];
                            sp <= sp - SP_W'(1);
                        end
                    end else if (instr_ready) begin
                        pc <= pc_next_seq;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avr_fetch_unit.sv
// Directed bench for avr_fetch_unit with a falling-edge registered ROM model.
module tb_avr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;
    logic [1:0]  stack_err;

    logic [15:0] rom [256];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ready;
        logic [7:0]  pc;
        logic        valid;
        logic [15:0] instr;
        logic [3:0]  sp;
    } vec_t;

    vec_t vecs [17];

    avr_fetch_unit #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (8),
        .STACK_DEPTH(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM registers its word on the falling edge, after pc has settled.
    always @(negedge clk) rom_data <= rom[rom_addr];

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ready);
        instr_ready = ready;
        @(negedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_pc", {24'd0, instr_pc}, 32'd0);
        checkOutput("reset_rom_addr", {24'd0, rom_addr}, 32'd0);
        checkOutput("reset_sp", {28'd0, dut.sp}, 32'd0);
        checkOutput("reset_halted", {31'd0, halted}, 32'd0);
        checkOutput("reset_stack_err", {30'd0, stack_err}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic runVectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            checkOutput($sformatf("vec%0d_pc", i), {24'd0, instr_pc}, {24'd0, vecs[i].pc});
            checkOutput($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].valid});
            checkOutput($sformatf("vec%0d_instr", i), {16'd0, instr}, {16'd0, vecs[i].instr});
            checkOutput($sformatf("vec%0d_sp", i), {28'd0, dut.sp}, {28'd0, vecs[i].sp});
            checkOutput($sformatf("vec%0d_halted", i), {31'd0, halted}, 32'd0);
            applyStimulus(vecs[i].ready);
        end
    endtask

    task automatic loadMainProgram();
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
        rom[0] = 16'hE005;
        rom[1] = 16'hC002;
        rom[2] = 16'hE01F;
        rom[3] = 16'h9508;
        rom[4] = 16'hE01A;
        rom[5] = 16'hDFFC;
        rom[6] = 16'hE124;
    endtask

    initial begin
        // Main program with full throughput, then with a 3-cycle stall at pc 4.
        vecs[0]  = '{1'b1, 8'd0, 1'b1, 16'hE005, 4'd0};
        vecs[1]  = '{1'b1, 8'd1, 1'b0, 16'hC002, 4'd0};
        vecs[2]  = '{1'b1, 8'd4, 1'b1, 16'hE01A, 4'd0};
        vecs[3]  = '{1'b1, 8'd5, 1'b0, 16'hDFFC, 4'd0};
        vecs[4]  = '{1'b1, 8'd2, 1'b1, 16'hE01F, 4'd1};
        vecs[5]  = '{1'b1, 8'd3, 1'b0, 16'h9508, 4'd1};
        vecs[6]  = '{1'b1, 8'd6, 1'b1, 16'hE124, 4'd0};
        vecs[7]  = '{1'b1, 8'd0, 1'b1, 16'hE005, 4'd0};
        vecs[8]  = '{1'b1, 8'd1, 1'b0, 16'hC002, 4'd0};
        vecs[9]  = '{1'b0, 8'd4, 1'b1, 16'hE01A, 4'd0};
        vecs[10] = '{1'b0, 8'd4, 1'b1, 16'hE01A, 4'd0};
        vecs[11] = '{1'b0, 8'd4, 1'b1, 16'hE01A, 4'd0};
        vecs[12] = '{1'b1, 8'd4, 1'b1, 16'hE01A, 4'd0};
        vecs[13] = '{1'b1, 8'd5, 1'b0, 16'hDFFC, 4'd0};
        vecs[14] = '{1'b1, 8'd2, 1'b1, 16'hE01F, 4'd1};
        vecs[15] = '{1'b1, 8'd3, 1'b0, 16'h9508, 4'd1};
        vecs[16] = '{1'b1, 8'd6, 1'b1, 16'hE124, 4'd0};

        rst_n       = 1'b0;
        instr_ready = 1'b1;
        rom_data    = 16'h0000;
        loadMainProgram();

        $display("[TB] scenario 1: call/return program");
        doReset(2);
        runVectors(0, 6);
        checkOutput("s1_after_pc", {24'd0, instr_pc}, 32'd7);

        $display("[TB] scenario 2: stall at pc 4");
        instr_ready = 1'b1;
        doReset(1);
        runVectors(7, 16);

        $display("[TB] scenario 3: rjmp to self and wrapping rjmp");
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
        rom[10] = 16'hCFFF;
        instr_ready = 1'b1;
        doReset(1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("s3_self_pc", {24'd0, instr_pc}, 32'd10);
            checkOutput("s3_self_valid", {31'd0, instr_valid}, 32'd0);
            checkOutput("s3_self_halted", {31'd0, halted}, 32'd0);
            applyStimulus(1'b0);
        end
        rom[10] = 16'hC0FA;
        instr_ready = 1'b1;
        doReset(1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1);
        checkOutput("s3_wrap_src_pc", {24'd0, instr_pc}, 32'd10);
        checkOutput("s3_wrap_src_valid", {31'd0, instr_valid}, 32'd0);
        applyStimulus(1'b0);
        checkOutput("s3_wrap_dst_pc", {24'd0, instr_pc}, 32'd5);
        checkOutput("s3_wrap_dst_valid", {31'd0, instr_valid}, 32'd1);

        $display("[TB] scenario 4: recursive rcall overflow");
        rom[10] = 16'h0000;
        rom[0]  = 16'hDFFF;
        instr_ready = 1'b1;
        doReset(1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("s4_sp", {28'd0, dut.sp}, i);
            checkOutput("s4_pc", {24'd0, instr_pc}, 32'd0);
            applyStimulus(1'b1);
        end
        checkOutput("s4_full_sp", {28'd0, dut.sp}, 32'd8);
        checkOutput("s4_full_halted", {31'd0, halted}, 32'd0);
        checkOutput("s4_full_err", {30'd0, stack_err}, 32'd0);
        applyStimulus(1'b1);
        for (int i = 0; i < 2; i++) begin
            checkOutput("s4_ovf_err", {30'd0, stack_err}, 32'd1);
            checkOutput("s4_ovf_halted", {31'd0, halted}, 32'd1);
            checkOutput("s4_ovf_pc", {24'd0, instr_pc}, 32'd0);
            checkOutput("s4_ovf_sp", {28'd0, dut.sp}, 32'd8);
            checkOutput("s4_ovf_valid", {31'd0, instr_valid}, 32'd0);
            checkOutput("s4_ovf_stack7", {24'd0, dut.stack[7]}, 32'd1);
            applyStimulus(1'b1);
        end

        $display("[TB] scenario 5: ret underflow after reset");
        rom[0] = 16'h9508;
        doReset(1);
        checkOutput("s5_pre_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("s5_pre_halted", {31'd0, halted}, 32'd0);
        applyStimulus(1'b1);
        checkOutput("s5_err", {30'd0, stack_err}, 32'd2);
        checkOutput("s5_halted", {31'd0, halted}, 32'd1);
        checkOutput("s5_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("s5_pc", {24'd0, instr_pc}, 32'd0);
        rom[0] = 16'h0000;
        doReset(1);
        checkOutput("s5_post_valid", {31'd0, instr_valid}, 32'd1);

        $display("[TB] scenario 6: reset during a stalled call nest");
        rom[0] = 16'hD001;
        rom[2] = 16'hD001;
        rom[4] = 16'hD001;
        rom[6] = 16'h0001;
        instr_ready = 1'b1;
        doReset(1);
        applyStimulus(1'b1);
        checkOutput("s6_pc2", {24'd0, instr_pc}, 32'd2);
        applyStimulus(1'b1);
        checkOutput("s6_pc4", {24'd0, instr_pc}, 32'd4);
        applyStimulus(1'b1);
        checkOutput("s6_pc6", {24'd0, instr_pc}, 32'd6);
        checkOutput("s6_sp3", {28'd0, dut.sp}, 32'd3);
        checkOutput("s6_valid", {31'd0, instr_valid}, 32'd1);
        applyStimulus(1'b0);
        checkOutput("s6_stall_pc", {24'd0, instr_pc}, 32'd6);
        rom[0] = 16'h9508;
        doReset(1);
        applyStimulus(1'b0);
        checkOutput("s6_unf_err", {30'd0, stack_err}, 32'd2);
        checkOutput("s6_unf_halted", {31'd0, halted}, 32'd1);

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
